// File: rtl/ddr2_port_arb.sv
// Two-requester arbiter for the single ddr2_mgr command port: the display read path
// has priority, a read-streak limit guarantees write progress, and a watchdog recovers stalls.
module ddr2_port_arb #(
  parameter int ADDR_W       = 25,
  parameter int LEN_W        = 10,
  parameter int RD_BURST_MAX = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic              mem_clk0,
  input  logic              mem_rst_n,
  input  logic              rd_mem_req,
  input  logic [ADDR_W-1:0] rd_mem_addr,
  input  logic [LEN_W-1:0]  rd_xfr_len,
  output logic              rd_mem_grant,
  input  logic              wr_mem_req,
  input  logic [ADDR_W-1:0] wr_mem_addr,
  input  logic [LEN_W-1:0]  wr_xfr_len,
  output logic              wr_mem_grant,
  output logic              mgr_req,
  output logic              mgr_rnw,
  output logic [ADDR_W-1:0] mgr_addr,
  output logic [LEN_W-1:0]  mgr_xfr_len,
  input  logic              mgr_grant,
  input  logic              mgr_done,
  output logic              busy,
  output logic              timeout_err
);
  localparam int STRK_W = $clog2(RD_BURST_MAX + 1);
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, XFR} state_t;

  state_t            state_q, state_d;
  logic [STRK_W-1:0] streak_q, streak_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              rnw_q, rnw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;

  logic tmo, sel_wr, own_grant, any_req;

  assign any_req   = rd_mem_req | wr_mem_req;
  assign tmo       = (timer_q == TMR_W'(TIMEOUT - 1));
  assign sel_wr    = wr_mem_req & (~rd_mem_req | (streak_q >= STRK_W'(RD_BURST_MAX)));
  // The watchdog beats a grant arriving on the expiry cycle in REQ.
  assign own_grant = (state_q == REQ) & mgr_grant & ~tmo;

  always_ff @(posedge mem_clk0) begin
    if (!mem_rst_n) begin
      state_q  <= IDLE;
      streak_q <= '0;
      timer_q  <= '0;
      rnw_q    <= 1'b1;
      addr_q   <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = REQ;
      REQ:     if (tmo) state_d = IDLE;
               else if (mgr_grant) state_d = XFR;
      XFR:     if (mgr_done || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d  = '0;
    streak_d = streak_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    len_d    = len_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          rnw_d  = ~sel_wr;
          addr_d = sel_wr ? wr_mem_addr : rd_mem_addr;
          len_d  = sel_wr ? wr_xfr_len  : rd_xfr_len;
        end
      end
      REQ: begin
        timer_d = own_grant ? '0 : timer_q + 1'b1;
        if (tmo) err_d = 1'b1;
      end
      XFR: begin
        timer_d = timer_q + 1'b1;
        if (tmo && !mgr_done) err_d = 1'b1;
      end
      default: ;
    endcase
    if (own_grant) begin
      if (rnw_q && wr_mem_req)
        streak_d = (streak_q == STRK_W'(RD_BURST_MAX)) ? streak_q : streak_q + 1'b1;
      else
        streak_d = '0;
    end
  end

  always_comb begin
    mgr_req      = (state_q == REQ);
    busy         = (state_q != IDLE);
    rd_mem_grant = own_grant & rnw_q;
    wr_mem_grant = own_grant & ~rnw_q;
    mgr_rnw      = rnw_q;
    mgr_addr     = addr_q;
    mgr_xfr_len  = len_q;
    timeout_err  = err_q;
  end
endmodule

// File: tb/tb_ddr2_port_arb.sv
// Randomized bench for ddr2_port_arb against a transaction-phase reference model,
// plus directed read-streak and watchdog scenarios.
module tb_ddr2_port_arb;
  localparam int ADDR_W = 25;
  localparam int LEN_W  = 10;
  localparam int RBM    = 4;
  localparam int TMO    = 64;

  logic              mem_clk0, mem_rst_n;
  logic              rd_mem_req, wr_mem_req, rd_mem_grant, wr_mem_grant;
  logic [ADDR_W-1:0] rd_mem_addr, wr_mem_addr, mgr_addr;
  logic [LEN_W-1:0]  rd_xfr_len, wr_xfr_len, mgr_xfr_len;
  logic              mgr_req, mgr_rnw, mgr_grant, mgr_done, busy, timeout_err;

  ddr2_port_arb #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_BURST_MAX(RBM), .TIMEOUT(TMO)) dut (
    .mem_clk0(mem_clk0), .mem_rst_n(mem_rst_n),
    .rd_mem_req(rd_mem_req), .rd_mem_addr(rd_mem_addr), .rd_xfr_len(rd_xfr_len),
    .rd_mem_grant(rd_mem_grant),
    .wr_mem_req(wr_mem_req), .wr_mem_addr(wr_mem_addr), .wr_xfr_len(wr_xfr_len),
    .wr_mem_grant(wr_mem_grant),
    .mgr_req(mgr_req), .mgr_rnw(mgr_rnw), .mgr_addr(mgr_addr), .mgr_xfr_len(mgr_xfr_len),
    .mgr_grant(mgr_grant), .mgr_done(mgr_done), .busy(busy), .timeout_err(timeout_err)
  );

  initial mem_clk0 = 1'b0;
  always #5 mem_clk0 = ~mem_clk0;

  int n_chk = 0, n_fail = 0;

  // Reference model: phase 0 = no command, 1 = command offered, 2 = transfer running.
  int                m_ph = 0, m_streak = 0, m_age = 0;
  bit                m_rnw = 1'b1, m_err = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [LEN_W-1:0]  m_len = '0;

  int rd_rate, wr_rate, g_rate, d_rate;
  bit rst_k, clr_req, rd_seen, wr_seen;
  bit seq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit w, expire;
    if (!mem_rst_n) begin
      m_ph = 0; m_streak = 0; m_age = 0; m_rnw = 1'b1; m_addr = '0; m_len = '0; m_err = 1'b0;
      return;
    end
    expire = (m_age == TMO - 1);
    case (m_ph)
      0: if (rd_mem_req || wr_mem_req) begin
           w      = wr_mem_req && (!rd_mem_req || m_streak >= RBM);
           m_rnw  = !w;
           m_addr = w ? wr_mem_addr : rd_mem_addr;
           m_len  = w ? wr_xfr_len : rd_xfr_len;
           m_ph   = 1; m_age = 0;
         end
      1: if (expire) begin m_err = 1'b1; m_ph = 0; end
         else if (mgr_grant) begin
           m_ph = 2; m_age = 0;
           if (m_rnw && wr_mem_req) m_streak = (m_streak < RBM) ? m_streak + 1 : RBM;
           else m_streak = 0;
         end else m_age++;
      default: if (mgr_done) m_ph = 0;
               else if (expire) begin m_err = 1'b1; m_ph = 0; end
               else m_age++;
    endcase
  endtask

  task automatic cycle();
    bit eg;
    mem_rst_n = rst_k;
    if (!rst_k && clr_req) begin
      rd_mem_req = 1'b0; wr_mem_req = 1'b0;
    end else begin
      if (rd_seen) rd_mem_req = 1'b0;
      else if (!rd_mem_req && $urandom_range(99) < rd_rate) begin
        rd_mem_req = 1'b1; rd_mem_addr = ADDR_W'($urandom); rd_xfr_len = LEN_W'($urandom);
      end
      if (wr_seen) wr_mem_req = 1'b0;
      else if (!wr_mem_req && $urandom_range(99) < wr_rate) begin
        wr_mem_req = 1'b1; wr_mem_addr = ADDR_W'($urandom); wr_xfr_len = LEN_W'($urandom);
      end
    end
    mgr_grant = rst_k && ($urandom_range(99) < g_rate);
    mgr_done  = ($urandom_range(99) < d_rate);
    @(negedge mem_clk0);
    eg = (m_ph == 1) && mgr_grant && (m_age != TMO - 1);
    chk("mgr_req",     32'(mgr_req),      32'(m_ph == 1));
    chk("busy",        32'(busy),         32'(m_ph != 0));
    chk("mgr_rnw",     32'(mgr_rnw),      32'(m_rnw));
    chk("mgr_addr",    32'(mgr_addr),     32'(m_addr));
    chk("mgr_len",     32'(mgr_xfr_len),  32'(m_len));
    chk("rd_grant",    32'(rd_mem_grant), 32'(eg && m_rnw));
    chk("wr_grant",    32'(wr_mem_grant), 32'(eg && !m_rnw));
    chk("timeout_err", 32'(timeout_err),  32'(m_err));
    rd_seen = rd_mem_grant;
    wr_seen = wr_mem_grant;
    if (rd_mem_grant) seq.push_back(1'b1);
    if (wr_mem_grant) seq.push_back(1'b0);
    @(posedge mem_clk0);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clean_reset();
    rst_k = 1'b0; clr_req = 1'b1;
    run(2);
    rst_k = 1'b1; clr_req = 1'b0;
  endtask

  initial begin
    bit exp_pat [10];
    int gcount;
    exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    mem_rst_n = 1'b0; rd_mem_req = 1'b0; wr_mem_req = 1'b0;
    rd_mem_addr = '0; wr_mem_addr = '0; rd_xfr_len = '0; wr_xfr_len = '0;
    mgr_grant = 1'b0; mgr_done = 1'b0;
    rd_seen = 1'b0; wr_seen = 1'b0;
    rd_rate = 0; wr_rate = 0; g_rate = 0; d_rate = 0;
    @(posedge mem_clk0);
    #1;
    clean_reset();
    run(3);

    // Random traffic with stray grant/done pulses and occasional mid-run resets.
    rd_rate = 30; wr_rate = 30; g_rate = 40; d_rate = 20;
    for (int i = 0; i < 3000; i++) begin
      rst_k = ($urandom_range(299) != 0);
      cycle();
    end
    rst_k = 1'b1;
    d_rate = 2; g_rate = 10;
    run(1500);

    // Both requesters saturated, mgr always ready: read streak limit yields RRRRW.
    clean_reset();
    rd_rate = 100; wr_rate = 100; g_rate = 100; d_rate = 100;
    seq.delete();
    run(80);
    chk("burst_len", 32'(seq.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < seq.size(); i++)
      chk($sformatf("burst_%0d", i), 32'(seq[i]), 32'(exp_pat[i]));

    // Transfer never completes: watchdog fires, later requests still served.
    clean_reset();
    rd_rate = 100; wr_rate = 0; g_rate = 100; d_rate = 0;
    run(100);
    chk("tmo_flag", 32'(timeout_err), 32'd1);
    d_rate = 50;
    seq.delete();
    run(60);
    gcount = seq.size();
    chk("tmo_recover", 32'(gcount > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
